// File: rtl/rast_fb_writer_if.sv
// rast_fb_writer_if
//   Pixel stream from the rasterizer plus the single-pixel framebuffer
//   write port.
//   master : rasterizer / memory side (drives pixels and fb_wr_busy)
//   slave  : rast_fb_writer (drives the ready and the write request)
//   Signals:
//     rast_pixel_rdy, rast_color_input[2:0], rast_width[9:0],
//     rast_height[8:0], rast_done, read_rast_pixel_rdy,
//     fb_wr_en, fb_wr_addr[19:0], fb_wr_data[2:0], fb_wr_busy
interface rast_fb_writer_if;
  logic        rast_pixel_rdy;
  logic [2:0]  rast_color_input;
  logic [9:0]  rast_width;
  logic [8:0]  rast_height;
  logic        rast_done;
  logic        read_rast_pixel_rdy;
  logic        fb_wr_en;
  logic [19:0] fb_wr_addr;
  logic [2:0]  fb_wr_data;
  logic        fb_wr_busy;

  modport master (
    output rast_pixel_rdy, rast_color_input, rast_width, rast_height,
           rast_done, fb_wr_busy,
    input  read_rast_pixel_rdy, fb_wr_en, fb_wr_addr, fb_wr_data
  );

  modport slave (
    input  rast_pixel_rdy, rast_color_input, rast_width, rast_height,
           rast_done, fb_wr_busy,
    output read_rast_pixel_rdy, fb_wr_en, fb_wr_addr, fb_wr_data
  );
endinterface

// File: rtl/rast_fb_writer.sv
// rast_fb_writer
//   Accepts rasterizer pixels, converts (x,y) to a linear address in the
//   back buffer and issues single-pixel framebuffer writes through a
//   one-entry write register. On end-of-frame it drains the register,
//   waits for vertical blanking and swaps front/back buffers.
//   Ports:
//     clk, rst        : clock, synchronous active-high reset
//     bus (slave)     : pixel stream in, framebuffer write port out
//     disp_vblank     : display vertical blanking (clk domain level)
//     front_buf       : buffer currently scanned out
//     frame_swapped   : one-cycle pulse on swap
//     frame_count     : completed frames, wraps
//     bounds_err      : sticky out-of-range flag (RAST_FB_BOUNDS_CHECK_EN only)
//   Optional feature macro: RAST_FB_BOUNDS_CHECK_EN
//
//   state     | meaning
//   RUN       | accepting pixels
//   SWAP_WAIT | frame done; waiting for drain and vblank before swapping
module rast_fb_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic                   clk,
  input  logic                   rst,
  rast_fb_writer_if.slave        bus,
  input  logic                   disp_vblank,
  output logic                   front_buf,
  output logic                   frame_swapped,
  output logic [7:0]             frame_count
`ifdef RAST_FB_BOUNDS_CHECK_EN
  ,
  output logic                   bounds_err
`endif
);

  typedef enum logic {RUN, SWAP_WAIT} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_wr_valid;
  logic [19:0] r_wr_addr;
  logic [2:0]  r_wr_data;
  logic        r_front_buf;
  logic        r_frame_swapped;
  logic [7:0]  r_frame_count;

  logic        w_ready;
  logic        w_xfer;
  logic        w_retire;
  logic        w_load;
  logic        w_swap;
  logic [18:0] w_h19, w_w19, w_offset;

  // Ready must never look at rast_* inputs: the rasterizer derives
  // rast_done from it.
  assign w_ready  = (r_state == RUN) && !rst && (!r_wr_valid || !bus.fb_wr_busy);
  assign w_xfer   = bus.rast_pixel_rdy && w_ready;
  assign w_retire = r_wr_valid && !bus.fb_wr_busy;

  // y*640 + x as two shifts and adds
  assign w_h19    = {10'd0, bus.rast_height};
  assign w_w19    = {9'd0, bus.rast_width};
  assign w_offset = (w_h19 << 9) + (w_h19 << 7) + w_w19;

`ifdef RAST_FB_BOUNDS_CHECK_EN
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [9:0]  V_LIM = 10'(V_RES);
  logic w_oob;
  logic r_bounds_err;
  assign w_oob      = ({1'b0, bus.rast_width} >= H_LIM) || ({1'b0, bus.rast_height} >= V_LIM);
  assign w_load     = w_xfer && !w_oob;
  assign bounds_err = r_bounds_err;
`else
  logic w_unused_params;
  assign w_unused_params = (H_RES > 0) && (V_RES > 0);
  assign w_load = w_xfer;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    case (r_state)
      RUN: begin
        if (w_xfer && bus.rast_done) w_state_nxt = SWAP_WAIT;
      end
      SWAP_WAIT: begin
        // Drain is judged on the next-state view so the swap can land on
        // the same edge that retires the last write.
        if ((!r_wr_valid || w_retire) && disp_vblank) begin
          w_swap      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_wr_valid      <= 1'b0;
      r_wr_addr       <= '0;
      r_wr_data       <= '0;
      r_front_buf     <= 1'b0;
      r_frame_swapped <= 1'b0;
      r_frame_count   <= '0;
`ifdef RAST_FB_BOUNDS_CHECK_EN
      r_bounds_err    <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_frame_swapped <= w_swap;
      if (w_load) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= {~r_front_buf, w_offset};
        r_wr_data  <= bus.rast_color_input;
      end else if (w_retire) begin
        r_wr_valid <= 1'b0;
      end
      if (w_swap) begin
        r_front_buf   <= ~r_front_buf;
        r_frame_count <= r_frame_count + 8'd1;
      end
`ifdef RAST_FB_BOUNDS_CHECK_EN
      if (w_xfer && w_oob) r_bounds_err <= 1'b1;
`endif
    end
  end

  assign bus.read_rast_pixel_rdy = w_ready;
  assign bus.fb_wr_en            = r_wr_valid;
  assign bus.fb_wr_addr          = r_wr_addr;
  assign bus.fb_wr_data          = r_wr_data;
  assign front_buf               = r_front_buf;
  assign frame_swapped           = r_frame_swapped;
  assign frame_count             = r_frame_count;

endmodule
